// File: rtl/cursor_controller.sv
`default_nettype none
// ============================================================================
// Module   : cursor_controller
// Function : debounced direction levels -> single moves with hold auto-repeat
//            on a COLS x ROWS grid. Define CURSOR_WRAP_EN to wrap at the edges
//            (default: saturate).
// Revision : 1.0
// ============================================================================
module cursor_controller #(
    parameter int COLS          = 8,
    parameter int ROWS          = 6,
    parameter int XW            = 3,
    parameter int YW            = 3,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up,
    input  logic          right,
    input  logic          down,
    input  logic          left,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          move_pulse,
    output logic [1:0]    move_dir
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    localparam logic [XW-1:0] C_X_MAX     = XW'(COLS - 1);
    localparam logic [YW-1:0] C_Y_MAX     = YW'(ROWS - 1);
    localparam logic [31:0]   C_HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0]   C_REP_LAST  = 32'(REPEAT_CYCLES - 1);
`ifdef CURSOR_WRAP_EN
    localparam logic          C_WRAP      = 1'b1;
`else
    localparam logic          C_WRAP      = 1'b0;
`endif

    logic [3:0]    in_q;
    logic [1:0]    state, state_nxt;
    logic [31:0]   cnt, cnt_nxt;
    logic [1:0]    dir_q, dir_nxt;
    logic          issue;
    logic [1:0]    issue_dir;
    logic          valid_press;
    logic          held_same;
    logic [1:0]    press_dir;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic          moved;

    assign valid_press = $onehot(in_q);
    assign held_same   = (in_q == (4'b0001 << dir_q));

    always_comb begin
        press_dir = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (in_q[b]) press_dir = 2'(b);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            in_q  <= 4'd0;
            cnt   <= 32'd0;
            dir_q <= 2'd0;
        end else begin
            state <= state_nxt;
            in_q  <= {left, down, right, up};
            cnt   <= cnt_nxt;
            dir_q <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_q;
        issue     = 1'b0;
        issue_dir = dir_q;
        case (state)
            S_IDLE: begin
                if (valid_press) begin
                    issue     = 1'b1;
                    issue_dir = press_dir;
                    dir_nxt   = press_dir;
                    cnt_nxt   = 32'd0;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD, S_REPEAT: begin
                // Any change in the pressed set, including a second button, aborts the run.
                if (!held_same) begin
                    state_nxt = S_IDLE;
                end else if (cnt == ((state == S_HOLD) ? C_HOLD_LAST : C_REP_LAST)) begin
                    issue     = 1'b1;
                    cnt_nxt   = 32'd0;
                    state_nxt = S_REPEAT;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        x_nxt = cur_x;
        y_nxt = cur_y;
        if (issue) begin
            case (issue_dir)
                2'd0:    y_nxt = (cur_y != '0)      ? cur_y - YW'(1) : (C_WRAP ? C_Y_MAX : cur_y);
                2'd1:    x_nxt = (cur_x != C_X_MAX) ? cur_x + XW'(1) : (C_WRAP ? '0 : cur_x);
                2'd2:    y_nxt = (cur_y != C_Y_MAX) ? cur_y + YW'(1) : (C_WRAP ? '0 : cur_y);
                default: x_nxt = (cur_x != '0)      ? cur_x - XW'(1) : (C_WRAP ? C_X_MAX : cur_x);
            endcase
        end
        moved = (x_nxt != cur_x) || (y_nxt != cur_y);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x      <= '0;
            cur_y      <= '0;
            move_pulse <= 1'b0;
            move_dir   <= 2'd0;
        end else begin
            cur_x      <= x_nxt;
            cur_y      <= y_nxt;
            move_pulse <= moved;
            if (moved) move_dir <= issue_dir;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cursor_controller.sv
`default_nettype none
// Testbench for cursor_controller: directed scenarios plus random button
// patterns, scored against a behavioural grid model.
module tb_cursor_controller;

    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int HOLD = 4;
    localparam int REP  = 2;
`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b0, right = 1'b0, down = 1'b0, left = 1'b0;
    logic [2:0] cur_x, cur_y;
    logic       move_pulse;
    logic [1:0] move_dir;

    cursor_controller #(
        .COLS(COLS), .ROWS(ROWS), .XW(3), .YW(3),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst(rst),
        .up(up), .right(right), .down(down), .left(left),
        .cur_x(cur_x), .cur_y(cur_y),
        .move_pulse(move_pulse), .move_dir(move_dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int x;
        int y;
        int d;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    // Model state: position, tracked press, edges since the press started.
    int         cyc = 0;
    int         mx = 0, my = 0;
    bit         act = 1'b0;
    int         md = 0, mn = 0;
    logic [3:0] m_inq = 4'd0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, want, cyc);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mx = 0; my = 0; act = 1'b0; md = 0; mn = 0; m_inq = 4'd0;
        end else begin
            logic [3:0] p;
            bit         issue;
            int         nx, ny;
            cyc++;
            p     = m_inq;
            m_inq = {left, down, right, up};
            issue = 1'b0;
            if (act) begin
                if (p != (4'b0001 << md)) act = 1'b0;
                else begin
                    mn++;
                    if (mn == HOLD || (mn > HOLD && (mn - HOLD) % REP == 0)) issue = 1'b1;
                end
            end else if ($countones(p) == 1) begin
                for (int b = 0; b < 4; b++) if (p[b]) md = b;
                act   = 1'b1;
                mn    = 0;
                issue = 1'b1;
            end
            if (issue) begin
                nx = mx; ny = my;
                case (md)
                    0: ny = my - 1;
                    1: nx = mx + 1;
                    2: ny = my + 1;
                    default: nx = mx - 1;
                endcase
                if (nx < 0)        nx = WRAP ? COLS - 1 : 0;
                if (nx > COLS - 1) nx = WRAP ? 0 : COLS - 1;
                if (ny < 0)        ny = WRAP ? ROWS - 1 : 0;
                if (ny > ROWS - 1) ny = WRAP ? 0 : ROWS - 1;
                if (nx != mx || ny != my) sbq.push_back('{cyc, nx, ny, md});
                mx = nx; my = ny;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                chk("missed_pulse", 0, 1);
            end
            if (move_pulse) begin
                if (sbq.size() == 0) chk("spurious_pulse", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("pulse_edge", cyc, e.cyc);
                    chk("pulse_x", int'(cur_x), e.x);
                    chk("pulse_y", int'(cur_y), e.y);
                    chk("pulse_dir", int'(move_dir), e.d);
                end
            end
            chk("pos_x", int'(cur_x), mx);
            chk("pos_y", int'(cur_y), my);
        end
    end

    task automatic drive(input logic [3:0] v, input int n);
        {left, down, right, up} = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_x"}, int'(cur_x), 0);
        chk({tag, "_y"}, int'(cur_y), 0);
        chk({tag, "_pulse"}, int'(move_pulse), 0);
        chk({tag, "_dir"}, int'(move_dir), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_check("reset");
        rst = 1'b0;

        drive(4'b0000, 3);
        drive(4'b0010, 1);   // single tap right
        drive(4'b0000, 6);
        drive(4'b0100, 12);  // down held: repeat cadence
        drive(4'b0000, 4);
        drive(4'b1000, 1);
        drive(4'b0000, 3);
        drive(4'b1000, 1);
        drive(4'b0000, 3);
        drive(4'b0001, 1);
        drive(4'b0000, 3);
        drive(4'b0011, 10);  // up+right together
        drive(4'b0010, 10);  // up released
        drive(4'b0000, 3);
        drive(4'b0010, 1);
        drive(4'b0000, 3);
        drive(4'b0001, 1);
        drive(4'b0000, 3);

        // Reset in the middle of a held right, released while still held.
        drive(4'b0010, 7);
        rst = 1'b1;
        #1;
        reset_check("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(4'b0010, 9);
        drive(4'b0000, 3);

        for (int s = 0; s < 250; s++) begin
            int         r;
            logic [3:0] v;
            r = $urandom_range(0, 9);
            if (r < 6)      v = 4'(1 << $urandom_range(0, 3));
            else if (r < 8) v = 4'b0000;
            else            v = 4'($urandom_range(0, 15));
            drive(v, $urandom_range(1, 12));
        end

        drive(4'b0000, 5);
        chk("queue_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
